control_unit: RTL and testbench



---
 rtl/control_unit.sv | 199 +++++++++++++++++++
 tb/tb_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - RV32I main decoder with branch resolution and sticky illegal flag
// Ports:
//   clk_i, rst_ni            clock and async active-low reset (sticky flag only)
//   instr_i                  instruction word
//   zero_i, lt_i, ltu_i      comparator flags, used only by branches
//   reg_write_o .. store_type_o  combinational datapath controls
//   illegal_o                current instruction not decodable
//   illegal_seen_o           sticky, set on a clock edge with illegal_o=1

package cpu_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;
    typedef enum logic [2:0] {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU} load_type_t;
    typedef enum logic [1:0] {ST_SB, ST_SH, ST_SW} store_type_t;
endpackage

module control_unit
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        lt_i,
    input  logic        ltu_i,
    output logic        reg_write_o,
    output logic        alu_src_o,
    output logic        mem_write_o,
    output logic        pc_src_o,
    output imm_src_t    imm_src_o,
    output result_src_t result_src_o,
    output alu_op_t     alu_ctrl_o,
    output load_type_t  load_type_o,
    output store_type_t store_type_o,
    output logic        illegal_o,
    output logic        illegal_seen_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign bit30  = instr_i[30];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    // Shared R/I-type funct3 -> ALU op; sub_sra picks the alternate op
    // on the two funct3 values that have one.
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic sub_sra);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = sub_sra ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = sub_sra ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        mem_write_o  = 1'b0;
        pc_src_o     = 1'b0;
        imm_src_o    = IMM_I;
        result_src_o = RES_ALU;
        alu_ctrl_o   = ALU_ADD;
        load_type_o  = LD_LW;
        store_type_o = ST_SW;
        illegal_o    = 1'b1;

        case (opcode)
            OP_OP: begin
                reg_write_o = 1'b1;
                alu_ctrl_o  = arith_op(funct3, bit30);
                illegal_o   = 1'b0;
            end
            OP_OPIMM: begin
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
                // bit30 is immediate data for ADDI; it only means SRA on shifts
                alu_ctrl_o  = arith_op(funct3, bit30 && (funct3 == F3_SR));
                illegal_o   = 1'b0;
            end
            OP_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    reg_write_o  = 1'b1;
                    alu_src_o    = 1'b1;
                    result_src_o = RES_MEM;
                    illegal_o    = 1'b0;
                    case (funct3)
                        3'b000:  load_type_o = LD_LB;
                        3'b001:  load_type_o = LD_LH;
                        3'b100:  load_type_o = LD_LBU;
                        3'b101:  load_type_o = LD_LHU;
                        default: load_type_o = LD_LW;
                    endcase
                end
            end
            OP_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    mem_write_o = 1'b1;
                    alu_src_o   = 1'b1;
                    imm_src_o   = IMM_S;
                    illegal_o   = 1'b0;
                    case (funct3)
                        3'b000:  store_type_o = ST_SB;
                        3'b001:  store_type_o = ST_SH;
                        default: store_type_o = ST_SW;
                    endcase
                end
            end
            OP_BRANCH: begin
                imm_src_o = IMM_B;
                illegal_o = 1'b0;
                case (funct3)
                    F3_BEQ:  pc_src_o = zero_i;
                    F3_BNE:  pc_src_o = !zero_i;
                    F3_BLT:  pc_src_o = lt_i;
                    F3_BGE:  pc_src_o = !lt_i;
                    F3_BLTU: pc_src_o = ltu_i;
                    F3_BGEU: pc_src_o = !ltu_i;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_JAL: begin
                reg_write_o  = 1'b1;
                imm_src_o    = IMM_J;
                result_src_o = RES_PC4;
                pc_src_o     = 1'b1;
                illegal_o    = 1'b0;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    reg_write_o  = 1'b1;
                    alu_src_o    = 1'b1;
                    result_src_o = RES_PC4;
                    pc_src_o     = 1'b1;
                    illegal_o    = 1'b0;
                end
            end
            OP_LUI, OP_AUIPC: begin
                // Operand A (zero vs PC) is muxed in the datapath
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
                imm_src_o   = IMM_U;
                illegal_o   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_seen_o <= 1'b0;
        end else if (illegal_o) begin
            illegal_seen_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a table-driven model
module tb_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic        rw;
        logic        as;
        logic        mw;
        logic        pc;
        imm_src_t    is;
        result_src_t rs;
        alu_op_t     alu;
        load_type_t  ld;
        store_type_t st;
        logic        ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;

    logic        reg_write, alu_src, mem_write, pc_src, illegal, illegal_seen;
    imm_src_t    imm_src;
    result_src_t result_src;
    alu_op_t     alu_ctrl;
    load_type_t  load_type;
    store_type_t store_type;

    int n_vec = 0;
    int n_err = 0;

    ctl_t obs;
    ctl_t exp_c;

    assign obs = {reg_write, alu_src, mem_write, pc_src, imm_src, result_src,
                  alu_ctrl, load_type, store_type, illegal};

    always #5 clk = ~clk;

    control_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_i        (instr),
        .zero_i         (zero),
        .lt_i           (lt),
        .ltu_i          (ltu),
        .reg_write_o    (reg_write),
        .alu_src_o      (alu_src),
        .mem_write_o    (mem_write),
        .pc_src_o       (pc_src),
        .imm_src_o      (imm_src),
        .result_src_o   (result_src),
        .alu_ctrl_o     (alu_ctrl),
        .load_type_o    (load_type),
        .store_type_o   (store_type),
        .illegal_o      (illegal),
        .illegal_seen_o (illegal_seen)
    );

    localparam ctl_t DEFAULT_CTL = '{1'b0, 1'b0, 1'b0, 1'b0, IMM_I, RES_ALU,
                                     ALU_ADD, LD_LW, ST_SW, 1'b1};

    // Reference model: mnemonic-level rules, one lookup per instruction class.
    function automatic ctl_t model(input logic [31:0] ins, input logic z, input logic l, input logic lu);
        ctl_t e;
        logic [6:0] op;
        logic [2:0] f3;
        alu_op_t base [8];
        load_type_t ldt [8];
        logic taken [8];
        base  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        ldt   = '{LD_LB, LD_LH, LD_LW, LD_LW, LD_LBU, LD_LHU, LD_LW, LD_LW};
        taken = '{z, !z, 1'b0, 1'b0, l, !l, lu, !lu};
        op = ins[6:0];
        f3 = ins[14:12];
        e = DEFAULT_CTL;
        if (op == 7'h33 || op == 7'h13) begin
            e.rw  = 1'b1;
            e.as  = (op == 7'h13);
            e.ill = 1'b0;
            e.alu = base[f3];
            if (ins[30] && f3 == 3'd5) e.alu = ALU_SRA;
            if (ins[30] && f3 == 3'd0 && op == 7'h33) e.alu = ALU_SUB;
        end else if (op == 7'h03 && f3 != 3'd3 && f3 < 3'd6) begin
            e.rw = 1'b1; e.as = 1'b1; e.rs = RES_MEM; e.ld = ldt[f3]; e.ill = 1'b0;
        end else if (op == 7'h23 && f3 < 3'd3) begin
            e.mw = 1'b1; e.as = 1'b1; e.is = IMM_S; e.ill = 1'b0;
            e.st = (f3 == 3'd0) ? ST_SB : (f3 == 3'd1) ? ST_SH : ST_SW;
        end else if (op == 7'h63) begin
            e.is  = IMM_B;
            e.pc  = taken[f3];
            e.ill = (f3 == 3'd2 || f3 == 3'd3);
        end else if (op == 7'h6F) begin
            e.rw = 1'b1; e.is = IMM_J; e.rs = RES_PC4; e.pc = 1'b1; e.ill = 1'b0;
        end else if (op == 7'h67 && f3 == 3'd0) begin
            e.rw = 1'b1; e.as = 1'b1; e.rs = RES_PC4; e.pc = 1'b1; e.ill = 1'b0;
        end else if (op == 7'h37 || op == 7'h17) begin
            e.rw = 1'b1; e.as = 1'b1; e.is = IMM_U; e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [2:0] f3, input logic b30);
        return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
    endfunction

    // Drive one vector while clear of the rising edge and let it settle.
    task automatic apply(input logic [31:0] ins, input logic z, input logic l, input logic lu);
        instr = ins; zero = z; lt = l; ltu = lu;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL reset_seen got=%b exp=0", illegal_seen);
        end
        apply(enc_r(7'h33, 3'd0, 1'b1), 1'b0, 1'b0, 1'b0);
        exp_c = model(instr, zero, lt, ltu);
        n_vec++;
        if (obs !== exp_c || alu_ctrl !== ALU_SUB) begin
            n_err++; $display("FAIL reset_comb got=%h exp=%h", obs, exp_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        alu_op_t seq [10];
        seq = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA};
        for (int k = 0; k < 10; k++) begin
            logic [2:0] f3;
            f3 = (k < 8) ? 3'(k) : ((k == 8) ? 3'd0 : 3'd5);
            apply(enc_r(7'h33, f3, k >= 8), 1'($urandom), 1'($urandom), 1'($urandom));
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c || alu_ctrl !== seq[k] || reg_write !== 1'b1 || alu_src !== 1'b0
                || result_src !== RES_ALU || pc_src !== 1'b0) begin
                n_err++; $display("FAIL rtype k=%0d got=%h exp=%h alu=%0d", k, obs, exp_c, seq[k]);
            end
        end
    endtask

    task automatic test_itype();
        logic [2:0] f3s [7];
        logic [11:0] imms [7];
        alu_op_t want [7];
        f3s  = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5};
        imms = '{12'h001, 12'h0F0, 12'h0F0, 12'h0F0, 12'h001, 12'h001, 12'h401};
        want = '{ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA};
        for (int k = 0; k < 7; k++) begin
            apply(enc_i(7'h13, f3s[k], imms[k]), 1'b0, 1'b0, 1'b0);
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c || alu_ctrl !== want[k] || alu_src !== 1'b1) begin
                n_err++; $display("FAIL itype k=%0d got=%h exp=%h", k, obs, exp_c);
            end
        end
        // ADDI with a negative immediate sets bit30 but must stay ADD
        apply(enc_i(7'h13, 3'd0, 12'hC00), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (alu_ctrl !== ALU_ADD || illegal !== 1'b0) begin
            n_err++; $display("FAIL addi_bit30 got=%0d exp=%0d", alu_ctrl, ALU_ADD);
        end
    endtask

    task automatic test_load();
        for (int f = 0; f < 8; f++) begin
            apply(enc_i(7'h03, 3'(f), 12'd4), 1'($urandom), 1'($urandom), 1'($urandom));
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c) begin
                n_err++; $display("FAIL load f3=%0d got=%h exp=%h", f, obs, exp_c);
            end
        end
        apply(enc_i(7'h03, 3'd3, 12'd4), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== DEFAULT_CTL) begin
            n_err++; $display("FAIL load_f3_011 got=%h exp=%h", obs, DEFAULT_CTL);
        end
    endtask

    task automatic test_store();
        for (int f = 0; f < 4; f++) begin
            apply(enc_s(3'(f), 12'd8), 1'($urandom), 1'($urandom), 1'($urandom));
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c) begin
                n_err++; $display("FAIL store f3=%0d got=%h exp=%h", f, obs, exp_c);
            end
        end
    endtask

    task automatic test_branch();
        for (int f = 0; f < 8; f++) begin
            for (int v = 1; v >= 0; v--) begin
                apply(enc_r(7'h63, 3'(f), 1'b0), 1'(v), 1'(v), 1'(v));
                exp_c = model(instr, zero, lt, ltu);
                n_vec++;
                if (obs !== exp_c) begin
                    n_err++; $display("FAIL branch f3=%0d flags=%0d got=%h exp=%h", f, v, obs, exp_c);
                end
            end
        end
        // BLT vs BLTU must follow their own flag
        apply(enc_r(7'h63, 3'd4, 1'b0), 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (pc_src !== 1'b0) begin
            n_err++; $display("FAIL blt_ltu_only got=%b exp=0", pc_src);
        end
        apply(enc_r(7'h63, 3'd6, 1'b0), 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (pc_src !== 1'b1) begin
            n_err++; $display("FAIL bltu_ltu got=%b exp=1", pc_src);
        end
    endtask

    task automatic test_jump_u();
        logic [31:0] ins [5];
        ins = '{32'h0080_00EF, enc_i(7'h67, 3'd0, 12'd0), enc_i(7'h67, 3'd1, 12'd0),
                32'h1234_51B7, 32'h0000_1197};
        for (int k = 0; k < 5; k++) begin
            apply(ins[k], 1'($urandom), 1'($urandom), 1'($urandom));
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c) begin
                n_err++; $display("FAIL jump_u k=%0d got=%h exp=%h", k, obs, exp_c);
            end
        end
        apply(32'h0080_00EF, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (result_src !== RES_PC4 || imm_src !== IMM_J || pc_src !== 1'b1 || reg_write !== 1'b1) begin
            n_err++; $display("FAIL jal_fields got=%h", obs);
        end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        apply(enc_i(7'h13, 3'd0, 12'd1), 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL seen_legal got=%b exp=0", illegal_seen);
        end
        apply(32'h0000_007F, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (obs !== DEFAULT_CTL || illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL opcode_7f got=%h exp=%h seen=%b", obs, DEFAULT_CTL, illegal_seen);
        end
        @(posedge clk); #1;
        apply(enc_i(7'h13, 3'd0, 12'd1), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (illegal_seen !== 1'b1) begin
            n_err++; $display("FAIL seen_set got=%b exp=1", illegal_seen);
        end
        @(posedge clk); #1;
        n_vec++;
        if (illegal_seen !== 1'b1) begin
            n_err++; $display("FAIL seen_hold got=%b exp=1", illegal_seen);
        end
        #2 rst_n = 1'b0; #1;
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL seen_async_clear got=%b exp=0", illegal_seen);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(3) != 0) ins[6:0] = ops[$urandom_range(8)];
            apply(ins, 1'($urandom), 1'($urandom), 1'($urandom));
            exp_c = model(instr, zero, lt, ltu);
            n_vec++;
            if (obs !== exp_c) begin
                n_err++; $display("FAIL random k=%0d instr=%h got=%h exp=%h", k, ins, obs, exp_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_store();
        test_branch();
        test_jump_u();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
